window_3x3_line_buffer: RTL and testbench

WINDOW_3X3_LINE_BUFFER -- requirements
Module: window_3x3_line_buffer

---
 rtl/window_3x3_line_buffer.sv | 203 ++++++++++++++++++++
 tb/tb_window_3x3_line_buffer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_line_buffer.sv
// 3x3 sliding-window generator over a raster stream using two line buffers.
// Optional frame_err output is built only when FRAME_ERR_EN is defined.
module window_3x3_line_buffer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [7:0] in_pixel,
    output logic [7:0] pixel0,
    output logic [7:0] pixel1,
    output logic [7:0] pixel2,
    output logic [7:0] pixel3,
    output logic [7:0] pixel4,
    output logic [7:0] pixel5,
    output logic [7:0] pixel6,
    output logic [7:0] pixel7,
    output logic [7:0] pixel8,
    output logic       win_valid,
    output logic       win_eof
`ifdef FRAME_ERR_EN
    ,
    output logic       frame_err
`endif
);

    localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_ZERO = CW'(0);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_ZERO = RW'(0);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic [7:0]    win_q [9];
    logic [7:0]    win_d [9];
    logic          win_valid_q, win_valid_d;
    logic          win_eof_q, win_eof_d;

    logic [7:0]    lb0_q [IMG_WIDTH];
    logic [7:0]    lb1_q [IMG_WIDTH];

    logic          accept_s;
    logic          last_s;
    logic [RW-1:0] cur_row_s;
    logic [CW-1:0] cur_col_s;

    // Acceptance, effective pixel position, and next position/state.
    always_comb begin
        accept_s  = 1'b0;
        last_s    = 1'b0;
        cur_row_s = row_q;
        cur_col_s = col_q;
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;

        case (state_q)
            IDLE:    accept_s = in_valid & in_sof;
            ACTIVE:  accept_s = in_valid;
            default: accept_s = 1'b0;
        endcase

        // A start-of-frame pixel is always taken as (0,0), even mid-frame.
        if (in_sof) begin
            cur_row_s = ROW_ZERO;
            cur_col_s = COL_ZERO;
        end else begin
            cur_row_s = row_q;
            cur_col_s = col_q;
        end

        last_s = accept_s && (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);

        if (!accept_s) begin
            state_d = state_q;
            row_d   = row_q;
            col_d   = col_q;
        end else if (last_s) begin
            state_d = IDLE;
            row_d   = ROW_ZERO;
            col_d   = COL_ZERO;
        end else if (cur_col_s == COL_LAST) begin
            state_d = ACTIVE;
            row_d   = cur_row_s + ROW_ONE;
            col_d   = COL_ZERO;
        end else begin
            state_d = ACTIVE;
            row_d   = cur_row_s;
            col_d   = cur_col_s + COL_ONE;
        end
    end

    // Window shift: the new right-hand column is {lb1, lb0, incoming pixel}.
    always_comb begin
        for (int i = 0; i < 9; i++) begin
            win_d[i] = win_q[i];
        end
        win_valid_d = 1'b0;
        win_eof_d   = 1'b0;
        if (accept_s) begin
            win_d[0]    = win_q[1];
            win_d[1]    = win_q[2];
            win_d[2]    = lb1_q[cur_col_s];
            win_d[3]    = win_q[4];
            win_d[4]    = win_q[5];
            win_d[5]    = lb0_q[cur_col_s];
            win_d[6]    = win_q[7];
            win_d[7]    = win_q[8];
            win_d[8]    = in_pixel;
            win_valid_d = (cur_row_s >= ROW_TWO) && (cur_col_s >= COL_TWO);
            win_eof_d   = last_s;
        end else begin
            win_valid_d = 1'b0;
            win_eof_d   = 1'b0;
        end
    end

    // Control and window registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= ROW_ZERO;
            col_q       <= COL_ZERO;
            win_valid_q <= 1'b0;
            win_eof_q   <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= 8'd0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            win_valid_q <= win_valid_d;
            win_eof_q   <= win_eof_d;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    // Line buffers need no reset: rows 0 and 1 of each frame refill them before any valid window.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb1_q[cur_col_s] <= lb0_q[cur_col_s];
            lb0_q[cur_col_s] <= in_pixel;
        end
    end

`ifdef FRAME_ERR_EN
    logic frame_err_q, frame_err_d;

    // Flags a stray pixel in IDLE or a start-of-frame that lands mid-frame.
    always_comb begin
        frame_err_d = 1'b0;
        if (!in_valid) begin
            frame_err_d = 1'b0;
        end else if (state_q == IDLE) begin
            frame_err_d = ~in_sof;
        end else begin
            frame_err_d = in_sof & ((row_q != ROW_ZERO) | (col_q != COL_ZERO));
        end
    end

    // Error pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err = frame_err_q;
`endif

    assign pixel0    = win_q[0];
    assign pixel1    = win_q[1];
    assign pixel2    = win_q[2];
    assign pixel3    = win_q[3];
    assign pixel4    = win_q[4];
    assign pixel5    = win_q[5];
    assign pixel6    = win_q[6];
    assign pixel7    = win_q[7];
    assign pixel8    = win_q[8];
    assign win_valid = win_valid_q;
    assign win_eof   = win_eof_q;

endmodule

// File: tb/tb_window_3x3_line_buffer.sv
// Randomised self-checking bench for window_3x3_line_buffer on a 5x4 image,
// compared against a frame-array reference model.
module tb_window_3x3_line_buffer;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_pixel = 8'd0;
    logic [7:0] pixel0, pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8;
    logic       win_valid, win_eof;
`ifdef FRAME_ERR_EN
    logic       frame_err;
`endif

    window_3x3_line_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
        .pixel0(pixel0), .pixel1(pixel1), .pixel2(pixel2), .pixel3(pixel3), .pixel4(pixel4),
        .pixel5(pixel5), .pixel6(pixel6), .pixel7(pixel7), .pixel8(pixel8),
        .win_valid(win_valid), .win_eof(win_eof)
`ifdef FRAME_ERR_EN
        , .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the current frame as a 2-D image plus the expected raster position.
    bit         m_active = 1'b0;
    int         m_r = 0;
    int         m_c = 0;
    int         img [H][W];
    logic [7:0] exp_win [9];
    bit         exp_valid, exp_eof, exp_err;
    int         win_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] first_p0, first_p4, first_p8;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        logic [7:0] obs [9];
        obs = '{pixel0, pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8};
        for (int k = 0; k < 9; k++) check_eq($sformatf("%s_pixel%0d", tag, k), 32'(obs[k]), 32'd0);
        check_eq({tag, "_win_valid"}, 32'(win_valid), 32'd0);
        check_eq({tag, "_win_eof"}, 32'(win_eof), 32'd0);
`ifdef FRAME_ERR_EN
        check_eq({tag, "_frame_err"}, 32'(frame_err), 32'd0);
`endif
    endtask

    task automatic drive(input bit v, input bit sof, input logic [7:0] pix);
        logic [7:0] obs [9];
        in_valid = v;
        in_sof   = sof;
        in_pixel = pix;
        exp_err   = v && ((!m_active && !sof) || (m_active && sof && (m_r != 0 || m_c != 0)));
        exp_valid = 1'b0;
        exp_eof   = 1'b0;
        if (v && (m_active || sof)) begin
            if (sof) begin
                m_r = 0;
                m_c = 0;
            end
            img[m_r][m_c] = int'(pix);
            if (m_r >= 2 && m_c >= 2) begin
                exp_valid = 1'b1;
                for (int k = 0; k < 9; k++) exp_win[k] = 8'(img[m_r - 2 + k / 3][m_c - 2 + k % 3]);
            end
            exp_eof = (m_r == H - 1) && (m_c == W - 1);
            if (exp_eof) begin
                m_active = 1'b0;
                m_r = 0;
                m_c = 0;
            end else begin
                m_active = 1'b1;
                m_c++;
                if (m_c == W) begin
                    m_c = 0;
                    m_r++;
                end
            end
        end
        @(posedge clk);
        #1;
        obs = '{pixel0, pixel1, pixel2, pixel3, pixel4, pixel5, pixel6, pixel7, pixel8};
        check_eq("win_valid", 32'(win_valid), 32'(exp_valid));
        check_eq("win_eof", 32'(win_eof), 32'(exp_eof));
        if (exp_valid) begin
            for (int k = 0; k < 9; k++) check_eq($sformatf("pixel%0d", k), 32'(obs[k]), 32'(exp_win[k]));
        end
`ifdef FRAME_ERR_EN
        check_eq("frame_err", 32'(frame_err), 32'(exp_err));
        if (frame_err) err_cnt++;
`endif
        if (win_valid) begin
            if (win_cnt == 0) begin
                first_p0 = pixel0;
                first_p4 = pixel4;
                first_p8 = pixel8;
            end
            win_cnt++;
        end
    endtask

    // gap_mode: 0 continuous, 1 one idle cycle after each pixel, 2 random 0..2 idle cycles.
    task automatic send_frame(input int gap_mode, input bit rnd_pix, input string tag);
        win_cnt = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b1, (r == 0 && c == 0), rnd_pix ? 8'($urandom) : 8'(r * 16 + c));
                if (gap_mode == 1) drive(1'b0, 1'($urandom), 8'($urandom));
                if (gap_mode == 2) begin
                    int gaps = $urandom_range(0, 2);
                    for (int g = 0; g < gaps; g++) drive(1'b0, 1'($urandom), 8'($urandom));
                end
            end
        end
        check_eq({tag, "_window_count"}, 32'(win_cnt), 32'((W - 2) * (H - 2)));
    endtask

    task automatic check_ramp_frame(input string tag);
        check_eq({tag, "_first_p0"}, 32'(first_p0), 32'h00);
        check_eq({tag, "_first_p4"}, 32'(first_p4), 32'h11);
        check_eq({tag, "_first_p8"}, 32'(first_p8), 32'h22);
        check_eq({tag, "_last_p0"}, 32'(pixel0), 32'h12);
        check_eq({tag, "_last_p4"}, 32'(pixel4), 32'h23);
        check_eq({tag, "_last_p8"}, 32'(pixel8), 32'h34);
    endtask

    initial begin
        // Reset state.
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all_zero("after_release");

        // Pixels before any start-of-frame are ignored.
        err_cnt = 0;
        win_cnt = 0;
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'($urandom));
        check_eq("presof_windows", 32'(win_cnt), 32'd0);
`ifdef FRAME_ERR_EN
        check_eq("presof_err_pulses", 32'(err_cnt), 32'd7);
`endif

        // Continuous ramp frame, then a stray pixel proves the FSM returned to IDLE.
        send_frame(0, 1'b0, "cont");
        check_ramp_frame("cont");
        drive(1'b1, 1'b0, 8'hAA);
        drive(1'b0, 1'b0, 8'h00);

        // Same frame with in_valid toggling.
        send_frame(1, 1'b0, "toggle");
        check_ramp_frame("toggle");

        // Restart with in_sof at (2,1).
        err_cnt = 0;
        for (int i = 0; i < 2 * W + 1; i++) drive(1'b1, (i == 0), 8'($urandom));
        send_frame(0, 1'b0, "restart");
        check_ramp_frame("restart");
`ifdef FRAME_ERR_EN
        check_eq("restart_err_pulses", 32'(err_cnt), 32'd1);
`endif

        // Asynchronous reset at (3,2), then a fresh frame.
        for (int i = 0; i < 3 * W + 2; i++) drive(1'b1, (i == 0), 8'($urandom));
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_pixel = 8'h5A;
        rst_n    = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check_all_zero("held_reset");
        m_active = 1'b0;
        m_r = 0;
        m_c = 0;
        rst_n = 1'b1;
        win_cnt = 0;
        drive(1'b1, 1'b0, 8'h33);
        drive(1'b1, 1'b0, 8'h44);
        check_eq("post_reset_windows", 32'(win_cnt), 32'd0);
        send_frame(0, 1'b0, "post_reset");
        check_ramp_frame("post_reset");

        // Random frames with random gaps and pixel values.
        for (int f = 0; f < 4; f++) send_frame(2, 1'b1, $sformatf("rand_frame%0d", f));

        // Free-running random stream with occasional start-of-frame.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), 8'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
